// File: rtl/ped_request_ctrl_if.sv
// Pedestrian controller bus: push-button and lamp inputs from the street/light side,
// crossing request and indicators back out.
interface ped_request_ctrl_if;
    logic btn;
    logic R;
    logic G;
    logic Y;
    logic pass;
    logic walk;
    logic wait_lamp;
    logic err;

    modport master (output btn, R, G, Y, input pass, walk, wait_lamp, err);
    modport slave  (input btn, R, G, Y, output pass, walk, wait_lamp, err);
endinterface

// File: rtl/ped_request_ctrl.sv
// Pedestrian-side controller: debounces the push-button, requests a green phase,
// shows WALK while green is served, then enforces a cooldown; flags lamp faults.
module ped_request_ctrl #(
    parameter int unsigned CNT_W        = 6,
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned WAIT_MAX     = 8,
    parameter int unsigned COOLDOWN     = 20
) (
    input  logic              clk,
    input  logic              rst,
    ped_request_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_REQ,
        S_SERVE,
        S_COOLDOWN
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             err_q;
    logic             err_nxt;
    logic             pass_q;
    logic             wait_q;
    logic             lamp_bad;

    // Exactly one lamp lit is the only legal light indication.
    assign lamp_bad = !(({bus.R, bus.G, bus.Y} == 3'b100) ||
                        ({bus.R, bus.G, bus.Y} == 3'b010) ||
                        ({bus.R, bus.G, bus.Y} == 3'b001));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            err_q  <= 1'b0;
            pass_q <= 1'b0;
            wait_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            err_q  <= err_nxt;
            pass_q <= (state_nxt == S_REQ);
            wait_q <= (state_nxt == S_REQ);
        end
    end

    // Every limit is compared before incrementing, so cnt never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err_q | lamp_bad;
        unique case (state)
            S_IDLE: begin
                if (bus.btn) begin
                    state_nxt = S_DEBOUNCE;
                    cnt_nxt   = '0;
                end
            end
            S_DEBOUNCE: begin
                if (!bus.btn) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = S_REQ;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_REQ: begin
                if (bus.G) begin
                    state_nxt = S_SERVE;
                    cnt_nxt   = '0;
                end else if (cnt == WAIT_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_SERVE: begin
                if (!bus.G) begin
                    state_nxt = S_COOLDOWN;
                    cnt_nxt   = '0;
                end
            end
            S_COOLDOWN: begin
                if (cnt == COOL_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.pass      = pass_q;
    assign bus.wait_lamp = wait_q;
    assign bus.walk      = (state == S_SERVE) & bus.G;
    assign bus.err       = err_q;

endmodule
